// File: rtl/frame_serializer.sv
// Frame serializer: holds an N-sample signed reference frame and streams it out,
// highest index first, one sample per ena strobe, with repeat/continuous/stop/gap control.
module frame_serializer #(
    parameter int N   = 20,
    parameter int W   = 8,
    parameter int GAP = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    input  logic [3:0]   repeat_cnt,
    input  logic         stop,
    output logic [W-1:0] tx,
    output logic         tx_valid,
    output logic         busy,
    output logic         done,
    output logic         wr_err
);

    localparam logic [5:0]    N_LIM    = 6'(N);
    localparam logic [4:0]    IDX_TOP  = 5'(N - 1);
    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP
    } state_t;

    state_t        state_reg, state_next;
    logic [4:0]    idx_reg, idx_next;
    logic [3:0]    reps_reg, reps_next;
    logic          stop_pend_reg, stop_pend_next;
    logic [GW-1:0] gap_reg, gap_next;
    logic [W-1:0]  tx_reg, tx_next;
    logic          tx_valid_reg, tx_valid_next;
    logic          done_reg, done_next;
    logic          wr_err_reg, wr_err_next;

    logic          wr_ok;
    logic [W-1:0]  frame_word [N];

    // The buffer only accepts writes while idle, so a running frame never changes under us.
    assign wr_ok       = wr_en && (state_reg == S_IDLE) && ({1'b0, wr_addr} < N_LIM);
    assign wr_err_next = wr_en && !wr_ok;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_entry
            logic [W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_ok && (wr_addr == 5'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign frame_word[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        reps_next      = reps_reg;
        stop_pend_next = stop_pend_reg;
        gap_next       = gap_reg;
        tx_next        = tx_reg;
        tx_valid_next  = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    reps_next      = repeat_cnt;
                    idx_next       = IDX_TOP;
                    stop_pend_next = 1'b0;
                    state_next     = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    stop_pend_next = 1'b1;
                end
                if (ena) begin
                    tx_next       = frame_word[idx_reg];
                    tx_valid_next = 1'b1;
                    if (idx_reg != 5'd0) begin
                        idx_next = idx_reg - 5'd1;
                    end else if ((reps_reg == 4'd1) || stop_pend_reg) begin
                        // Last-frame decision uses the registered stop request only.
                        if (GAP > 0) begin
                            state_next = S_GAP;
                            gap_next   = '0;
                        end else begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        idx_next = IDX_TOP;
                        if (reps_reg != 4'd0) begin
                            reps_next = reps_reg - 4'd1;
                        end
                    end
                end
            end

            S_GAP: begin
                if (ena) begin
                    tx_next       = '0;
                    tx_valid_next = 1'b1;
                    if (gap_reg == GAP_LAST) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        gap_next = gap_reg + GW'(1);
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            idx_reg       <= IDX_TOP;
            reps_reg      <= '0;
            stop_pend_reg <= 1'b0;
            gap_reg       <= '0;
            tx_reg        <= '0;
            tx_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            reps_reg      <= reps_next;
            stop_pend_reg <= stop_pend_next;
            gap_reg       <= gap_next;
            tx_reg        <= tx_next;
            tx_valid_reg  <= tx_valid_next;
            done_reg      <= done_next;
            wr_err_reg    <= wr_err_next;
        end
    end

    assign tx       = tx_reg;
    assign tx_valid = tx_valid_reg;
    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign wr_err   = wr_err_reg;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: two instances (no gap, 4-sample gap) share stimulus;
// a frame-level model queues expected samples, a negedge monitor pops and compares.
module tb_frame_serializer;

    localparam int N = 20;
    localparam int W = 8;
    localparam int G = 4;

    typedef struct packed {
        logic [W-1:0] val;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena, wr_en, start, stop;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [3:0]   repeat_cnt;

    logic [W-1:0] tx0, tx4;
    logic         tv0, tv4, busy0, busy4, done0, done4, err0, err4;

    int   checks   = 0;
    int   failures = 0;
    int   model_frame [N];
    exp_t q0[$];
    exp_t q4[$];
    exp_t e0, e4;
    bit   done0_seen, done4_seen;

    always #5 clk = ~clk;

    frame_serializer #(.N(N), .W(W), .GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .repeat_cnt(repeat_cnt), .stop(stop),
        .tx(tx0), .tx_valid(tv0), .busy(busy0), .done(done0), .wr_err(err0)
    );

    frame_serializer #(.N(N), .W(W), .GAP(G)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .repeat_cnt(repeat_cnt), .stop(stop),
        .tx(tx4), .tx_valid(tv4), .busy(busy4), .done(done4), .wr_err(err4)
    );

    task automatic cmp(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every tx_valid must match the head of the queue; done only on the final sample.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tv0) begin
                if (q0.size() == 0) begin
                    cmp("unexpected_tx0", 32'sd1, 32'sd0);
                end else begin
                    e0 = q0.pop_front();
                    cmp("tx0", $signed(tx0), $signed(e0.val));
                    cmp("done0", done0, e0.last);
                    cmp("busy0", busy0, !e0.last);
                end
            end else if (done0) begin
                cmp("stray_done0", 32'sd1, 32'sd0);
            end
            if (done0) done0_seen = 1'b1;

            if (tv4) begin
                if (q4.size() == 0) begin
                    cmp("unexpected_tx4", 32'sd1, 32'sd0);
                end else begin
                    e4 = q4.pop_front();
                    cmp("tx4", $signed(tx4), $signed(e4.val));
                    cmp("done4", done4, e4.last);
                    cmp("busy4", busy4, !e4.last);
                end
            end else if (done4) begin
                cmp("stray_done4", 32'sd1, 32'sd0);
            end
            if (done4) done4_seen = 1'b1;
        end
    end

    // Frame-level model: whole frames, high index first, then the gap zeros.
    task automatic push_expect(input int r, input int stop_after);
        int frames;
        int total0;
        int n;
        exp_t e;
        if (r == 0) frames = stop_after / N + 1;
        else if (stop_after > 0 && (stop_after / N + 1) < r) frames = stop_after / N + 1;
        else frames = r;
        total0 = frames * N;
        n = 0;
        for (int f = 0; f < frames; f++) begin
            for (int k = N - 1; k >= 0; k--) begin
                n++;
                e.val  = W'(model_frame[k]);
                e.last = (n == total0);
                q0.push_back(e);
                e.last = 1'b0;
                q4.push_back(e);
            end
        end
        for (int z = 0; z < G; z++) begin
            e.val  = '0;
            e.last = (z == G - 1);
            q4.push_back(e);
        end
    endtask

    task automatic write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = W'(data);
        tick();
        wr_en = 1'b0;
        if (addr < N) model_frame[addr] = data;
        cmp("wr_err0", err0, (addr >= N));
        cmp("wr_err4", err4, (addr >= N));
    endtask

    task automatic run(input int r, input int period, input int stop_after,
                       input int rst_after, input bit busy_write, input bit write_at_start);
        int  sent, cyc, sa, sd;
        bit  pend_stop, stopped, wrote, chk_err;
        sent = 0; cyc = 0; pend_stop = 0; stopped = 0; wrote = 0; chk_err = 0;
        if (write_at_start) begin
            sa = $urandom_range(0, N - 1);
            sd = $signed(8'($urandom));
            model_frame[sa] = sd;
            wr_en   = 1'b1;
            wr_addr = 5'(sa);
            wr_data = W'(sd);
        end
        push_expect(r, stop_after);
        done0_seen = 1'b0;
        done4_seen = 1'b0;
        start      = 1'b1;
        repeat_cnt = 4'(r);
        ena        = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        ena   = 1'b0;
        wr_en = 1'b0;
        cmp("busy0_after_start", busy0, 1);
        cmp("busy4_after_start", busy4, 1);
        if (write_at_start) cmp("wr_err_at_start", err0, 0);
        while (!(done0_seen && done4_seen)) begin
            if (cyc >= 3000) begin
                cmp("timeout_waiting_done", 32'sd1, 32'sd0);
                break;
            end
            ena       = (period <= 1) || (cyc % period == 0);
            stop      = pend_stop;
            pend_stop = 1'b0;
            wr_en     = 1'b0;
            if (busy_write && sent == 3 && !wrote) begin
                wr_en   = 1'b1;
                wr_addr = 5'd5;
                wr_data = 8'h7F;
                wrote   = 1'b1;
                chk_err = 1'b1;
            end
            tick();
            cyc++;
            if (chk_err) begin
                cmp("wr_err0_busy", err0, 1);
                cmp("wr_err4_busy", err4, 1);
                chk_err = 1'b0;
            end
            if (tv0) sent++;
            if (stop_after > 0 && sent == stop_after && !stopped) begin
                pend_stop = 1'b1;
                stopped   = 1'b1;
            end
            if (rst_after > 0 && sent == rst_after) begin
                ena   = 1'b0;
                stop  = 1'b0;
                wr_en = 1'b0;
                rst_n = 1'b0;
                #2;
                cmp("rst_tx0", tx0, 0);
                cmp("rst_busy0", busy0, 0);
                cmp("rst_busy4", busy4, 0);
                tick();
                cmp("rst_done0", done0, 0);
                cmp("rst_tv4", tv4, 0);
                q0.delete();
                q4.delete();
                for (int i = 0; i < N; i++) model_frame[i] = 0;
                rst_n = 1'b1;
                break;
            end
        end
        ena   = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        repeat (3) tick();
        cmp("q0_drained", q0.size(), 0);
        cmp("q4_drained", q4.size(), 0);
        $display("run r=%0d period=%0d stop_after=%0d rst_after=%0d samples=%0d",
                 r, period, stop_after, rst_after, sent);
    endtask

    initial begin
        int r, sa;
        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        wr_addr = '0; wr_data = '0; repeat_cnt = '0;
        for (int i = 0; i < N; i++) model_frame[i] = 0;
        repeat (3) tick();
        cmp("reset_tx", tx0, 0);
        cmp("reset_tv", tv0, 0);
        cmp("reset_busy", busy0, 0);
        cmp("reset_done", done4, 0);
        cmp("reset_err", err4, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < N; i++) write(i, i - 10);
        run(1, 3, 0, 0, 0, 0);          // single frame 9..-10
        run(3, 3, 0, 0, 0, 0);          // three frames, gap instance adds zeros
        run(0, 2, 27, 0, 0, 0);         // continuous, stop during frame 2
        run(1, 2, 0, 0, 1, 0);          // write while busy rejected
        write(20, 33);                  // out-of-range write rejected
        run(1, 3, 0, 0, 0, 0);          // entry 5 still -5
        run(2, 3, 0, 10, 0, 0);         // reset mid-run, no done
        run(1, 2, 0, 0, 0, 0);          // all-zero frame after reset

        for (int i = 0; i < N; i++) write(i, $signed(8'($urandom)));
        write(19, -128);
        write(0, 127);
        run(1, 1, 0, 0, 0, 0);          // ena held high, extremes preserved
        run(2, 1, 0, 0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            write($urandom_range(0, N - 1), $signed(8'($urandom)));
            r = $urandom_range(0, 3);
            if (r == 0) sa = $urandom_range(1, 55);
            else if ($urandom_range(0, 1) == 1) sa = $urandom_range(1, 70);
            else sa = 0;
            run(r, $urandom_range(2, 4), sa, 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
